pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Output-side elastic stage for the DSP datapath pipeline; the consumer end of the enable-register pipeline.
- Takes valid/data from an upstream pipeline register and presents it to a downstream consumer that can stall.
- Holds up to two words, main plus skid, so in_ready can be registered, full throughput is kept, and no data is lost under backpressure.
- A BYPASS parameter turns it into a pure wire for purely combinational paths.

Parameters:
- DATA_W, 18: width of the data path.
- BYPASS, 0: 0 = two-entry registered skid stage; 1 = combinational pass-through. With BYPASS=1: out_* = in_*, in_ready = out_ready, no state.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear, discards stored words.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  word available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  word presented downstream, always the main register.

Behaviour:
- Reset is decided as: reset rst, asynchronous, active-high; clock clk.
- While rst is high:
  - state = EMPTY; main_q and skid_q = 0.
  - out_valid = 0, in_ready = 0, out_data = 0.
  - in_ready goes to 1 on the first clock edge after rst deasserts.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the same rising edge.
- Outputs:
  - in_ready = (state != FULL), driven from a flop, never combinational from out_ready.
  - out_valid = (state != EMPTY); out_data = main_q.
- Latency: a word accepted on edge N is on out_data with out_valid=1 after edge N. One-cycle latency; throughput one word per cycle.
- EMPTY:
  - accept: main_q <= in_data, go to ONE.
  - No accept: stay in EMPTY.
- ONE:
  - accept & pop: main_q <= in_data, stay in ONE.
  - accept & !pop: skid_q <= in_data, go to FULL.
  - !accept & pop: go to EMPTY.
  - Neither: hold.
- FULL:
  - in_ready = 0, so no accept is possible.
  - pop: main_q <= skid_q, go to ONE.
  - No pop: hold.
- Ordering: strict FIFO order; the skid word never overtakes main.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change.
- Data registers load only on the transitions listed above; otherwise they hold. They are not cleared on pop.
- flush:
  - Synchronous and highest priority: state <= EMPTY.
  - Any accept or pop in that cycle is ignored; the word is dropped.
  - Data registers keep their values.
- rst mid-transfer: words in flight are lost; no out_valid glitch after release.
- BYPASS=1: rst and flush have no effect on the data path.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: counts cycles with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rst and by flush.
  - In BYPASS mode it counts out_valid & !out_ready of the pass-through.
- Not defined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package pipe_pkg:
  - Typedef skid_state_t: 2-bit enum EMPTY=0, ONE=1, FULL=2.
  - Constant STALL_CNT_W = 16.
- One natural sub-module, pipe_en_reg: DATA_W-wide load-enable register with async active-high reset to 0. Instantiated twice, for main_q and skid_q.
- The FSM and the optional counter stay in the top module.

Test Plan:
- Reset release: rst high 3 cycles, then low → out_valid=0 throughout; in_ready=0 during rst and 1 one edge after release.
- Streaming: out_ready=1, push 0x00001..0x00008 on consecutive cycles → same values out on consecutive cycles, each one cycle after its accept, in_ready stays 1.
- Backpressure: out_ready=0, push 0x11111 then 0x22222 → state FULL, in_ready=0, out_data held at 0x11111. Raise out_ready → 0x11111 then 0x22222, no loss or duplication.
- Random stall stress: 1000 words, random in_valid and out_ready at 50% each → scoreboard exact order match; out_data stable during every stall.
- Flush: stage FULL with 0x0AAAA/0x15555, assert flush together with in_valid=1 carrying 0x3FFFF → next cycle out_valid=0, in_ready=1, 0x3FFFF never appears at the output.
- BYPASS=1 plus stats: in_data=0x2A5A5, in_valid=1, out_ready=0 for 5 cycles → out_data=0x2A5A5 in the same cycle, in_ready=0. With PIPE_SKID_STATS_EN, stall_cnt=5.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the pipe_skid_reg output elastic stage.
package pipe_pkg;

  localparam int unsigned STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle around pipe_skid_reg: upstream in_* side and downstream out_* side.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 18
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_skid_reg_en_reg.sv
// Load-enable data register with asynchronous active-high clear to zero.
module pipe_en_reg #(
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry (main + skid) output elastic stage with registered in_ready; BYPASS=1 makes it a wire.
// Optional stall counter output enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter bit          BYPASS = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_skid_reg_if.slave         bus
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              main_ld, skid_ld, main_from_skid;
  logic [DATA_W-1:0] main_d, main_q, skid_q;
  logic              reg_out_valid;
  logic              accept, pop;

  assign reg_out_valid = (state_q != EMPTY);
  assign accept        = bus.in_valid & in_ready_q;
  assign pop           = reg_out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // in_ready is a flop: it reflects whether the next state leaves a free slot
    in_ready_d = (state_d != FULL);
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_en_reg #(.DATA_W(DATA_W)) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_en_reg #(.DATA_W(DATA_W)) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_ld),
    .d   (bus.in_data),
    .q   (skid_q)
  );

  // With BYPASS set the registered path is left unobserved and trims away
  assign bus.out_valid = BYPASS ? bus.in_valid  : reg_out_valid;
  assign bus.out_data  = BYPASS ? bus.in_data   : main_q;
  assign bus.in_ready  = BYPASS ? bus.out_ready : in_ready_q;

`ifdef PIPE_SKID_STATS_EN
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   stall;

  assign stall = bus.out_valid & ~bus.out_ready;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random-stall bench for pipe_skid_reg with a FIFO scoreboard; second instance covers BYPASS.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int unsigned W = 18;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_b;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(W)) bus   ();
  pipe_skid_reg_if #(.DATA_W(W)) bus_b ();

`ifdef PIPE_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] cnt;
  logic [STALL_CNT_W-1:0] cnt_b;
`endif

  pipe_skid_reg #(.DATA_W(W), .BYPASS(1'b0)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (cnt)
`endif
  );

  pipe_skid_reg #(.DATA_W(W), .BYPASS(1'b1)) u_byp (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_b),
    .bus   (bus_b)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (cnt_b)
`endif
  );

  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic [W-1:0] sb[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, update scoreboard, return #1 after posedge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic [W-1:0] exp;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_hold_data", {14'd0, bus.out_data}, {14'd0, prev_data});
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (bus.out_valid && ordy) begin
        check("pop_has_expected", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("out_data", {14'd0, bus.out_data}, {14'd0, exp});
        end
        pops++;
      end
      if (v && bus.in_ready) sb.push_back(d);
    end
    prev_stall = bus.out_valid & ~ordy & ~fl;
    prev_data  = bus.out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    logic [W-1:0] rd;
    logic rv, rr;

    rst = 1'b1;
    flush = 1'b0;
    flush_b = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data = '0;
    bus_b.out_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_data", {14'd0, bus.out_data}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rel_in_ready_pre_edge", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_post_edge", {31'd0, bus.in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming at full throughput
    pops = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b1, 1'b0);
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_latency_data", {14'd0, bus.out_data}, i);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("stream_pop_count", pops, 32'd8);
    check("stream_drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure fills main and skid
    cyc(1'b1, 18'h11111, 1'b0, 1'b0);
    cyc(1'b1, 18'h22222, 1'b0, 1'b0);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_out_data", {14'd0, bus.out_data}, 32'h11111);
    cyc(1'b1, 18'h33333, 1'b0, 1'b0);
    pops = 0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp_pop_count", pops, 32'd2);
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    check("bp_sb_empty", sb.size(), 32'd0);

    // Random stalls, 1000 words
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 1000; c++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rd = W'($urandom);
      if (rv && bus.in_ready) pushed++;
      cyc(rv, rd, rr, 1'b0);
    end
    check("rand_pushed", pushed, 32'd1000);
    for (int c = 0; c < 10 && sb.size() != 0; c++) cyc(1'b0, '0, 1'b1, 1'b0);
    check("rand_sb_drained", sb.size(), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("rand_out_idle", {31'd0, bus.out_valid}, 32'd0);

    // Flush while FULL with a concurrent input word
    cyc(1'b1, 18'h0AAAA, 1'b0, 1'b0);
    cyc(1'b1, 18'h15555, 1'b0, 1'b0);
    check("fl_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc(1'b1, 18'h3FFFF, 1'b0, 1'b1);
    check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef PIPE_SKID_STATS_EN
    check("fl_stall_cnt", {16'd0, cnt}, 32'd0);
`endif
    repeat (3) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("fl_no_output", {31'd0, bus.out_valid}, 32'd0);
    end

    // Bypass instance: combinational pass-through, stalled for 5 cycles
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 18'h2A5A5;
    bus_b.out_ready = 1'b0;
    #1;
    repeat (5) begin
      check("byp_out_data", {14'd0, bus_b.out_data}, 32'h2A5A5);
      check("byp_out_valid", {31'd0, bus_b.out_valid}, 32'd1);
      check("byp_in_ready", {31'd0, bus_b.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
`ifdef PIPE_SKID_STATS_EN
    check("byp_stall_cnt", {16'd0, cnt_b}, 32'd5);
`endif
    bus_b.out_ready = 1'b1;
    #1;
    check("byp_in_ready_follow", {31'd0, bus_b.in_ready}, 32'd1);
    bus_b.in_valid = 1'b0;
    #1;
    check("byp_valid_follow", {31'd0, bus_b.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
